// File: rtl/writeback_regfile_pkg.sv
// Shared widths and FSM encoding for the writeback stage.
//   WORD  : data word width in bits
//   W_RD  : register-number width; the file holds 2**W_RD entries
//   W_RET : retired-instruction counter width
package writeback_regfile_pkg;

  localparam int unsigned WORD  = 16;
  localparam int unsigned W_RD  = 3;
  localparam int unsigned W_RET = 16;
  localparam int unsigned NREGS = 2 ** W_RD;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two combinational read ports with
// write-through bypass so a value being written this cycle is seen by decode at once.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset (clears every entry)
//   we_i/waddr_i/wdata_i : write port, committed at posedge
//   raddr1_i/rdata1_o  : read port 1
//   raddr2_i/rdata2_o  : read port 2
// Build option: define WB_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_2r1w
  import writeback_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [W_RD-1:0] waddr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [W_RD-1:0] raddr1_i,
  output logic [WORD-1:0] rdata1_o,
  input  logic [W_RD-1:0] raddr2_i,
  output logic [WORD-1:0] rdata2_o
);

  logic [WORD-1:0] regs_q [NREGS];
  logic            we_eff;

`ifdef WB_ZERO_REG_EN
  // Writes to register 0 are dropped; the entry therefore stays at its reset value.
  assign we_eff = we_i & (waddr_i != '0);
`else
  assign we_eff = we_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_eff) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // we_eff already excludes index 0 when the zero register is enabled, so bypass
  // can never return non-zero data for it.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (we_eff && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (we_eff && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits execute results into the register file, serves two
// bypassed read ports to decode, owns the debug halt (stall back to execute) and
// counts retired instructions.
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   v_i, rd_num_i, wb_i, rd_data_i : execute result (valid, dest, write-enable, data)
//   stall_o                    : hold execute pipeline registers (high in HALT)
//   rs1/rs2_num_i, rs1/rs2_data_o : decode read ports
//   halt_req_i, resume_i       : debug halt request (level) and resume
//   halted_o                   : high in HALT
//   retired_o                  : wrapping count of accepted instructions
// Build option: WB_ZERO_REG_EN hardwires register 0 to zero (see regfile_2r1w).
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  input  logic [W_RD-1:0]  rd_num_i,
  input  logic             wb_i,
  input  logic [WORD-1:0]  rd_data_i,
  output logic             stall_o,
  input  logic [W_RD-1:0]  rs1_num_i,
  input  logic [W_RD-1:0]  rs2_num_i,
  output logic [WORD-1:0]  rs1_data_o,
  output logic [WORD-1:0]  rs2_data_o,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             halted_o,
  output logic [W_RET-1:0] retired_o
);

  wb_state_e        state_q, state_d;
  logic [W_RET-1:0] retired_q;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt request wins over a simultaneous resume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (halt_req_i) state_d = ST_HALT;
      ST_HALT: if (resume_i && !halt_req_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Accepting depends only on the registered state, so the result presented in the
  // cycle halt_req_i rises still retires.
  assign accept   = v_i & (state_q == ST_RUN);
  assign stall_o  = (state_q == ST_HALT);
  assign halted_o = stall_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (accept) begin
      retired_q <= retired_q + W_RET'(1);
    end
  end

  assign retired_o = retired_q;

  regfile_2r1w u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (accept & wb_i),
    .waddr_i  (rd_num_i),
    .wdata_i  (rd_data_i),
    .raddr1_i (rs1_num_i),
    .rdata1_o (rs1_data_o),
    .raddr2_i (rs2_num_i),
    .rdata2_o (rs2_data_o)
  );

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage directly downstream of the execute stage.
- Consumes the execute stage's valid, destination-register number, write-enable and result data, and commits results into the architectural register file.
- Provides two combinational read ports, with write-through bypass, to the decode stage.
- Owns the pipeline-wide debug halt: back-pressures execute via stall_o and counts retired instructions.

Parameters:
- WORD, 16, data word width in bits.
- W_RD, 3, register-number width; register file holds 2**W_RD entries.
- W_RET, 16, retired-instruction counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- v_i  input  1  execute stage result valid.
- rd_num_i  input  W_RD  destination register number.
- wb_i  input  1  result is to be written to the register file.
- rd_data_i  input  WORD  result data.
- stall_o  output  1  tells execute to hold its pipeline registers.
- rs1_num_i  input  W_RD  decode read port 1 register number.
- rs2_num_i  input  W_RD  decode read port 2 register number.
- rs1_data_o  output  WORD  read port 1 data.
- rs2_data_o  output  WORD  read port 2 data.
- halt_req_i  input  1  debug halt request, level.
- resume_i  input  1  debug resume, one-cycle pulse or level.
- halted_o  output  1  high while in HALT.
- retired_o  output  W_RET  count of retired instructions.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers are 0, state is RUN, retired_o is 0.
  - stall_o and halted_o are 0.
  - Reset asserted mid-HALT returns to RUN.
- FSM states: RUN, HALT.
  - RUN -> HALT at the posedge where halt_req_i is 1.
  - HALT -> RUN at the posedge where resume_i is 1 and halt_req_i is 0.
  - If halt_req_i and resume_i are both 1 in HALT, stay in HALT.
- stall_o = (state == HALT), taken combinationally from the state register. halted_o equals stall_o.
- Accept condition: accept = v_i & (state == RUN).
  - The input presented in the same cycle halt_req_i first rises is still accepted and retired, because the state is still RUN.
  - In HALT, v_i is ignored. Execute holds the pending result and re-presents it after resume.
- Commit: if accept & wb_i, then regs[rd_num_i] <= rd_data_i at the posedge.
  - If accept & ~wb_i, the register file is unchanged.
- Retire counter: retired_o increments by 1 on every accept, regardless of wb_i.
  - Wraps from 2**W_RET-1 to 0 without saturating or flagging.
- Read ports are combinational, zero latency:
  - rsN_data_o = rd_data_i when (accept & wb_i & rd_num_i == rsN_num_i); otherwise regs[rsN_num_i].
  - The two ports are independent. Both may address the same register, including the one being written.
- Writeback latency: a result written at posedge T is visible from the array at T+1 and via bypass during cycle T.
- No X propagation on reads of never-written registers; they read 0 from reset.

Optional Feature:
- Macro: WB_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to 0; writes with rd_num_i == 0 are dropped.
  - Bypass is suppressed for index 0, so reads of index 0 return 0.
  - Writes to register 0 still count as retired.
- Undefined: register 0 is an ordinary writable register.

Decomposition:
- Shared package/params include:
  - WORD, W_RD, W_RET.
  - FSM state encoding constants ST_RUN=1'b0, ST_HALT=1'b1.
- Natural sub-module: regfile_2r1w.
  - Contains the storage array, the async-reset clear, the two read ports with bypass, and the optional zero register.
  - writeback_regfile holds the FSM, the accept logic and the retire counter.

Test Plan:
- Reset then read: after reset release, rs1_num_i=5 and rs2_num_i=7 -> rs1_data_o=0, rs2_data_o=0, retired_o=0, stall_o=0.
- Write and bypass:
  - Drive v_i=1, wb_i=1, rd_num_i=3, rd_data_i=16'hBEEF with rs1_num_i=3 -> rs1_data_o=BEEF in the same cycle.
  - Next cycle, with v_i=0 -> still BEEF; retired_o=1.
- No-writeback retire: v_i=1, wb_i=0, rd_num_i=3, rd_data_i=16'h1234 -> reg3 stays BEEF, retired_o increments to 2.
- Halt/resume:
  - Pulse halt_req_i with v_i=1 writing reg2=16'h0042 -> the write commits and stall_o=1 from the next cycle.
  - While halted, v_i=1 with reg4=16'h0099 -> reg4 stays 0 and the counter is frozen.
  - resume_i with halt_req_i=0 -> stall_o=0 next cycle and the re-presented reg4 write commits.
- Counter wrap: preload via 65535 accepts (W_RET=16) then one more accept -> retired_o=0.
- WB_ZERO_REG_EN: write reg0=16'hFFFF -> rs1_num_i=0 gives 0 both in the bypass cycle and after; retired_o increments. Without the macro -> FFFF is read.
